// File: rtl/mips_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_hazard_unit
// Brief    : Scoreboard-driven load-use stall, operand-forwarding select and
//            taken-branch flush control for the 5-stage MIPS pipeline.
//            Optional feature macro: MIPS_HAZ_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mips_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int BR_STAGE   = 1,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_AW-1:0]          id_rs,
  input  logic [REG_AW-1:0]          id_rt,
  input  logic                       id_use_rs,
  input  logic                       id_use_rt,
  input  logic                       id_reg_write,
  input  logic [REG_AW-1:0]          id_dest,
  input  logic                       id_mem_read,
  input  logic                       branch_taken,
  output logic                       pc_en,
  output logic                       ifid_en,
  output logic                       idexe_bubble,
  output logic [BR_STAGE+1:0]        flush,
  output logic [$clog2(DEPTH+1)-1:0] fwd_a_sel,
  output logic [$clog2(DEPTH+1)-1:0] fwd_b_sel,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int c_SEL_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]             r_sb_valid;
  logic [DEPTH-1:0]             r_sb_load;
  logic [DEPTH-1:0][REG_AW-1:0] r_sb_dest;
  logic [CNT_W-1:0]             r_stall_cnt;
  logic [CNT_W-1:0]             r_flush_cnt;

  logic               w_a_hit;
  logic               w_b_hit;
  logic               w_a_load;
  logic               w_b_load;
  logic [c_SEL_W-1:0] w_a_sel;
  logic [c_SEL_W-1:0] w_b_sel;
  logic               w_hazard;
  logic               w_flush;
  logic               w_stall;
  logic               w_take;
  logic               w_new_valid;

  // Oldest-first scan so the youngest matching producer wins; WB is excluded
  // because the register file is write-first.
  always_comb begin
    w_a_hit  = 1'b0;
    w_b_hit  = 1'b0;
    w_a_load = 1'b0;
    w_b_load = 1'b0;
    w_a_sel  = '0;
    w_b_sel  = '0;
    for (int k = DEPTH-2; k >= 0; k--) begin
      if (id_valid && id_use_rs && (id_rs != '0) && r_sb_valid[k] && (r_sb_dest[k] == id_rs)) begin
        w_a_hit  = 1'b1;
        w_a_load = r_sb_load[k];
        w_a_sel  = c_SEL_W'(k + 1);
      end
      if (id_valid && id_use_rt && (id_rt != '0) && r_sb_valid[k] && (r_sb_dest[k] == id_rt)) begin
        w_b_hit  = 1'b1;
        w_b_load = r_sb_load[k];
        w_b_sel  = c_SEL_W'(k + 1);
      end
    end
  end

`ifdef MIPS_HAZ_FORWARD_EN
  assign w_hazard = (w_a_hit && w_a_load && (int'(w_a_sel) < LOAD_STAGE)) ||
                    (w_b_hit && w_b_load && (int'(w_b_sel) < LOAD_STAGE));
`else
  assign w_hazard = w_a_hit || w_b_hit;
`endif

  // A taken branch wins over a stall: the flush clears the same registers.
  assign w_flush     = branch_taken && !rst;
  assign w_stall     = w_hazard && !w_flush;
  assign w_take      = id_valid && !w_hazard && !branch_taken;
  assign w_new_valid = w_take && id_reg_write && (id_dest != '0);

  assign pc_en        = !w_stall;
  assign ifid_en      = !w_stall;
  assign idexe_bubble = w_stall;
  assign flush        = {(BR_STAGE+2){w_flush}};
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_valid  <= '0;
      r_sb_load   <= '0;
      r_sb_dest   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_sb_valid[0] <= w_new_valid;
      r_sb_dest[0]  <= id_dest;
      r_sb_load[0]  <= id_mem_read;
      for (int j = 1; j < DEPTH; j++) begin
        // Entries younger than the resolving branch are wrong-path work.
        r_sb_valid[j] <= r_sb_valid[j-1] && !(branch_taken && ((j - 1) < BR_STAGE));
        r_sb_dest[j]  <= r_sb_dest[j-1];
        r_sb_load[j]  <= r_sb_load[j-1];
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

`ifdef MIPS_HAZ_FORWARD_EN
  logic [c_SEL_W-1:0] r_fwd_a_sel;
  logic [c_SEL_W-1:0] r_fwd_b_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_a_sel <= '0;
      r_fwd_b_sel <= '0;
    end else begin
      r_fwd_a_sel <= (w_take && w_a_hit) ? w_a_sel : '0;
      r_fwd_b_sel <= (w_take && w_b_hit) ? w_b_sel : '0;
    end
  end

  assign fwd_a_sel = r_fwd_a_sel;
  assign fwd_b_sel = r_fwd_b_sel;
`else
  logic w_unused;
  assign w_unused  = ^{w_a_load, w_b_load, w_a_sel, w_b_sel};
  assign fwd_a_sel = '0;
  assign fwd_b_sel = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_hazard_unit
// Brief    : Self-checking bench for mips_hazard_unit; directed pipeline
//            scenarios plus randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_hazard_unit;

  localparam int REG_AW     = 5;
  localparam int DEPTH      = 3;
  localparam int BR_STAGE   = 1;
  localparam int LOAD_STAGE = 2;
  localparam int CNT_W      = 4;
  localparam int SEL_W      = $clog2(DEPTH+1);
  localparam int SAT        = (1 << CNT_W) - 1;
`ifdef MIPS_HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_rs = '0;
  logic [REG_AW-1:0] id_rt = '0;
  logic              id_use_rs = 1'b0;
  logic              id_use_rt = 1'b0;
  logic              id_reg_write = 1'b0;
  logic [REG_AW-1:0] id_dest = '0;
  logic              id_mem_read = 1'b0;
  logic              branch_taken = 1'b0;
  logic              pc_en;
  logic              ifid_en;
  logic              idexe_bubble;
  logic [BR_STAGE+1:0] flush;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  mips_hazard_unit #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .BR_STAGE(BR_STAGE),
    .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
    .id_dest(id_dest), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idexe_bubble(idexe_bubble), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // In-flight instruction list: index 0 is the instruction now in EXE.
  typedef struct packed {
    logic              w;
    logic [REG_AW-1:0] d;
    logic              ld;
  } ent_t;

  ent_t pipe[$];
  ent_t nxt_pipe[$];
  int   m_sc, m_fc, m_fa, m_fb;
  int   n_sc, n_fc, n_fa, n_fb;
  bit   pend = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string nm, int act, int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  function automatic void mreset();
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back('0);
    m_sc = 0; m_fc = 0; m_fa = 0; m_fb = 0;
  endfunction

  function automatic int youngest(logic [REG_AW-1:0] s, logic u);
    if (!id_valid || !u || s == 0) return -1;
    for (int i = 0; i < DEPTH-1; i++)
      if (pipe[i].w && pipe[i].d == s) return i;
    return -1;
  endfunction

  task automatic model_check();
    int   ia, ib;
    bit   st, br, take;
    ent_t e;
    if (rst) begin
      mreset();
      pend = 1'b0;
    end else if (pend) begin
      pipe = nxt_pipe;
      m_sc = n_sc; m_fc = n_fc; m_fa = n_fa; m_fb = n_fb;
    end
    br = branch_taken && !rst;
    ia = youngest(id_rs, id_use_rs);
    ib = youngest(id_rt, id_use_rt);
    if (FWD)
      st = (ia >= 0 && pipe[ia].ld && (ia + 1) < LOAD_STAGE) ||
           (ib >= 0 && pipe[ib].ld && (ib + 1) < LOAD_STAGE);
    else
      st = (ia >= 0) || (ib >= 0);
    chk("pc_en", pc_en, !(st && !br));
    chk("ifid_en", ifid_en, !(st && !br));
    chk("idexe_bubble", idexe_bubble, st && !br);
    chk("flush", int'(flush), br ? (1 << (BR_STAGE+2)) - 1 : 0);
    chk("fwd_a_sel", fwd_a_sel, m_fa);
    chk("fwd_b_sel", fwd_b_sel, m_fb);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
    if (!rst) begin
      take = id_valid && !st && !br;
      e = '0;
      if (take) begin
        e.w  = id_reg_write && (id_dest != 0);
        e.d  = id_dest;
        e.ld = id_mem_read;
      end
      nxt_pipe = pipe;
      nxt_pipe.push_front(e);
      void'(nxt_pipe.pop_back());
      if (br) for (int i = 0; i <= BR_STAGE; i++) nxt_pipe[i] = '0;
      n_fa = (FWD && take && ia >= 0) ? ia + 1 : 0;
      n_fb = (FWD && take && ib >= 0) ? ib + 1 : 0;
      n_sc = (st && !br) ? ((m_sc < SAT) ? m_sc + 1 : SAT) : m_sc;
      n_fc = br ? ((m_fc < SAT) ? m_fc + 1 : SAT) : m_fc;
      pend = 1'b1;
    end
  endtask

  task automatic set(bit v, int rs, int rt, bit urs, bit urt, bit wr, int dst, bit mr, bit br);
    id_valid = v; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
    id_use_rs = urs; id_use_rt = urt; id_reg_write = wr;
    id_dest = REG_AW'(dst); id_mem_read = mr; branch_taken = br;
  endtask

  task automatic nop();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nop();
    rst = 1'b1;
    settle();
    adv();
    rst = 1'b0;
  endtask

  // Count stall cycles until the held ID instruction issues (bounded).
  task automatic issue(output int nst);
    bit done;
    nst  = 0;
    done = 1'b0;
    for (int i = 0; i < 6 && !done; i++) begin
      settle();
      if (pc_en) done = 1'b1;
      else begin
        nst++;
        adv();
      end
    end
  endtask

  int nst;

  initial begin
    // ALU dependency: add $3,$1,$2 ; sub $4,$3,$1
    do_reset();
    chk("reset_pc_en", pc_en, 1);
    chk("reset_stall_cnt", stall_cnt, 0);
    set(1, 1, 2, 1, 1, 1, 3, 0, 0); settle(); adv();
    set(1, 3, 1, 1, 1, 1, 4, 0, 0); issue(nst);
    chk("alu_stalls", nst, FWD ? 0 : 2);
    adv(); nop(); settle();
    chk("alu_fwd_a", fwd_a_sel, FWD ? 1 : 0);
    chk("alu_fwd_b", fwd_b_sel, 0);
    chk("alu_stall_cnt", stall_cnt, FWD ? 0 : 2);
    adv();

    // Load-use: lw $5,0($0) ; add $6,$5,$5
    do_reset();
    set(1, 0, 0, 1, 0, 1, 5, 1, 0); settle(); adv();
    set(1, 5, 5, 1, 1, 1, 6, 0, 0); settle();
    chk("lu_pc_en", pc_en, 0);
    chk("lu_bubble", idexe_bubble, 1);
    adv(); issue(nst);
    chk("lu_extra_stalls", nst, FWD ? 0 : 1);
    adv(); nop(); settle();
    chk("lu_fwd_a", fwd_a_sel, FWD ? 2 : 0);
    chk("lu_fwd_b", fwd_b_sel, FWD ? 2 : 0);
    chk("lu_stall_cnt", stall_cnt, FWD ? 1 : 2);
    adv();

    // $zero destination and an unused matching rt never stall.
    do_reset();
    set(1, 1, 0, 1, 0, 1, 0, 0, 0); settle(); adv();
    set(1, 0, 0, 1, 1, 1, 8, 0, 0); settle();
    chk("zero_pc_en", pc_en, 1);
    adv();
    set(1, 1, 1, 1, 1, 1, 7, 1, 0); settle(); adv();
    set(1, 2, 7, 1, 0, 1, 9, 0, 0); settle();
    chk("unused_rt_pc_en", pc_en, 1);
    adv(); nop(); settle();
    chk("unused_rt_fwd_b", fwd_b_sel, 0);
    chk("zero_fwd_a", fwd_a_sel, 0);
    adv();

    // Taken branch while a load-use is pending in ID.
    do_reset();
    set(1, 0, 0, 1, 0, 1, 5, 1, 0); settle(); adv();
    set(1, 5, 5, 1, 1, 1, 6, 0, 1); settle();
    chk("br_flush", int'(flush), 7);
    chk("br_bubble", idexe_bubble, 0);
    chk("br_pc_en", pc_en, 1);
    adv();
    set(1, 5, 6, 1, 1, 1, 10, 0, 0); settle();
    chk("br_entries_dropped", pc_en, 1);
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);
    adv();

    // Asynchronous reset in the middle of a stall.
    do_reset();
    set(1, 0, 0, 1, 0, 1, 5, 1, 0); settle(); adv();
    set(1, 5, 0, 1, 0, 1, 6, 0, 0); issue(nst); adv();
    set(1, 0, 0, 1, 0, 1, 7, 1, 0); settle(); adv();
    set(1, 7, 0, 1, 0, 1, 8, 0, 0); settle();
    chk("mid_stall_pc_en", pc_en, 0);
    chk("mid_stall_cnt", stall_cnt, FWD ? 1 : 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc_en", pc_en, 1);
    chk("arst_bubble", idexe_bubble, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    settle(); adv();
    rst = 1'b0;

    // 20 back-to-back load-use pairs saturate the 4-bit stall counter.
    do_reset();
    for (int p = 0; p < 20; p++) begin
      set(1, 0, 0, 1, 0, 1, 5, 1, 0); settle(); adv();
      set(1, 5, 5, 1, 1, 1, 6, 0, 0); issue(nst); adv();
    end
    nop(); settle();
    chk("sat_stall_cnt", stall_cnt, 15);
    adv();

    // Randomized traffic in reset-separated segments.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        set($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 7, $urandom_range(0, 3),
            $urandom_range(0, 9) < 3, $urandom_range(0, 11) == 0);
        settle();
        adv();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
